// File: rtl/uart_rx_core_if.sv
// Receiver-side signal bundle: serial line in, deframed byte and status strobes out.
// The master is the receiver core; the slave is the consumer driving the line.
interface uart_rx_core_if;
  logic       Rx;
  logic [7:0] RxData;
  logic       RxDone;
  logic       FrameErr;
  logic       Busy;

  modport master (input Rx, output RxData, RxDone, FrameErr, Busy);
  modport slave  (output Rx, input RxData, RxDone, FrameErr, Busy);
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchronises Rx, samples each bit at its centre and reports
// a good byte with RxDone or a bad stop bit with FrameErr (both one-cycle pulses).
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int CNT_W        = 13
) (
  input  logic          Clk,
  input  logic          Rst,
  uart_rx_core_if.master bus
);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t           stateReg;
  logic [1:0]       syncReg;
  logic             rxS;
  logic [CNT_W-1:0] cntReg;
  logic [2:0]       bitIdxReg;
  logic [7:0]       shiftReg;
  logic [7:0]       rxDataReg;
  logic             rxDoneReg;
  logic             frameErrReg;
  logic             busyReg;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) syncReg <= 2'b11;
    else     syncReg <= {syncReg[0], bus.Rx};
  end

  assign rxS = syncReg[1];

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      stateReg    <= IDLE;
      cntReg      <= '0;
      bitIdxReg   <= '0;
      shiftReg    <= '0;
      rxDataReg   <= '0;
      rxDoneReg   <= 1'b0;
      frameErrReg <= 1'b0;
      busyReg     <= 1'b0;
    end else begin
      rxDoneReg   <= 1'b0;
      frameErrReg <= 1'b0;
      case (stateReg)
        IDLE: begin
          cntReg <= '0;
          if (!rxS) begin
            stateReg <= START;
            busyReg  <= 1'b1;
          end
        end
        START: begin
          if (cntReg == HALF_LAST) begin
            cntReg    <= '0;
            bitIdxReg <= '0;
            if (!rxS) begin
              stateReg <= DATA;
            end else begin
              stateReg <= IDLE;
              busyReg  <= 1'b0;
            end
          end else begin
            cntReg <= cntReg + 1'b1;
          end
        end
        DATA: begin
          if (cntReg == BIT_LAST) begin
            cntReg              <= '0;
            shiftReg[bitIdxReg] <= rxS;
            if (bitIdxReg == 3'd7) stateReg  <= STOP;
            else                   bitIdxReg <= bitIdxReg + 3'd1;
          end else begin
            cntReg <= cntReg + 1'b1;
          end
        end
        STOP: begin
          if (cntReg == BIT_LAST) begin
            cntReg <= '0;
            if (rxS) begin
              rxDataReg <= shiftReg;
              rxDoneReg <= 1'b1;
              stateReg  <= IDLE;
              busyReg   <= 1'b0;
            end else begin
              frameErrReg <= 1'b1;
              stateReg    <= WAIT_IDLE;
            end
          end else begin
            cntReg <= cntReg + 1'b1;
          end
        end
        WAIT_IDLE: begin
          // A held-low line (break) must release before a new start can be seen.
          cntReg <= '0;
          if (rxS) begin
            stateReg <= IDLE;
            busyReg  <= 1'b0;
          end
        end
        default: begin
          stateReg <= IDLE;
          cntReg   <= '0;
          busyReg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RxData   = rxDataReg;
  assign bus.RxDone   = rxDoneReg;
  assign bus.FrameErr = frameErrReg;
  assign bus.Busy     = busyReg;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame-level model predicts every strobe and the
// held RxData value, checked each cycle, plus literal checks on key results.
module tb_uart_rx_core;
  localparam int CLKS = 16;
  localparam int HALF = CLKS / 2;
  // Start edge to strobe: 2 sync flops + 1 detect cycle + half bit + 9 full bits.
  localparam int LAT  = 3 + HALF + 9 * CLKS;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  uart_rx_core_if bus ();

  uart_rx_core #(.CLKS_PER_BIT(CLKS), .CNT_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  typedef struct {
    int         at;
    logic       ok;
    logic [7:0] data;
  } ev_t;

  ev_t        expQ[$];
  logic [7:0] expData = 8'h00;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         doneCount = 0;
  int         feCount = 0;
  int         lastDoneCyc = 0;
  int         lastStart = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Per-cycle compare against the frame-level model.
  always @(negedge Clk) begin : compare
    logic expDone;
    logic expFe;
    expDone = 1'b0;
    expFe   = 1'b0;
    if (Rst) begin
      expData = 8'h00;
    end else begin
      while (expQ.size() > 0 && expQ[0].at < cyc) begin
        chk("missed_event", 32'(cyc), 32'(expQ[0].at));
        void'(expQ.pop_front());
      end
      if (expQ.size() > 0 && expQ[0].at == cyc) begin
        if (expQ[0].ok) begin
          expDone = 1'b1;
          expData = expQ[0].data;
        end else begin
          expFe = 1'b1;
        end
        void'(expQ.pop_front());
      end
    end
    chk("RxDone", 32'(bus.RxDone), 32'(expDone));
    chk("FrameErr", 32'(bus.FrameErr), 32'(expFe));
    chk("RxData", 32'(bus.RxData), 32'(expData));
    if (bus.RxDone === 1'b1) begin
      doneCount++;
      lastDoneCyc = cyc;
    end
    if (bus.FrameErr === 1'b1) feCount++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Drive one frame; extraLow keeps the line low after the stop bit before releasing.
  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int extraLow);
    logic [9:0] bits;
    ev_t        ev;
    bits      = {stopBit, b, 1'b0};
    lastStart = cyc;
    ev.at     = cyc + LAT;
    ev.ok     = stopBit;
    ev.data   = b;
    expQ.push_back(ev);
    for (int i = 0; i < 10; i++) begin
      bus.Rx = bits[i];
      tick(CLKS);
    end
    if (extraLow > 0) tick(extraLow);
    bus.Rx = 1'b1;
  endtask

  initial begin : stim
    int c;
    logic [7:0] v;
    bus.Rx = 1'b1;

    // 1: reset
    tick(3);
    chk("rst_RxData", 32'(bus.RxData), 32'h00);
    chk("rst_RxDone", 32'(bus.RxDone), 32'h0);
    chk("rst_FrameErr", 32'(bus.FrameErr), 32'h0);
    chk("rst_Busy", 32'(bus.Busy), 32'h0);
    Rst = 1'b0;
    tick(10);

    // 2: single frame
    sendFrame(8'hA5, 1'b1, 0);
    c = lastStart;
    tick(20);
    chk("A5_data", 32'(bus.RxData), 32'hA5);
    chk("A5_count", 32'(doneCount), 32'd1);
    chk("A5_latency", 32'(lastDoneCyc - c), 32'd155);
    chk("A5_fe", 32'(feCount), 32'd0);

    // 3: back-to-back, zero gap
    sendFrame(8'h00, 1'b1, 0);
    c = lastStart;
    sendFrame(8'hFF, 1'b1, 0);
    sendFrame(8'h3C, 1'b1, 0);
    tick(20);
    chk("b2b_count", 32'(doneCount), 32'd4);
    chk("b2b_data", 32'(bus.RxData), 32'h3C);
    chk("b2b_spacing", 32'(lastDoneCyc - c), 32'd475);

    // 4: start glitch
    c = cyc;
    bus.Rx = 1'b0;
    tick(4);
    bus.Rx = 1'b1;
    tick(c + 10 - cyc);
    chk("glitch_busy_hi", 32'(bus.Busy), 32'h1);
    tick(2);
    chk("glitch_busy_lo", 32'(bus.Busy), 32'h0);
    tick(20);
    chk("glitch_no_pulse", 32'(doneCount + feCount), 32'd4);
    sendFrame(8'h81, 1'b1, 0);
    tick(20);
    chk("81_data", 32'(bus.RxData), 32'h81);
    chk("81_count", 32'(doneCount), 32'd5);

    // 5: framing error with line held low
    sendFrame(8'h55, 1'b0, 40);
    c = lastStart;
    tick(2);
    chk("fe_busy_held", 32'(bus.Busy), 32'h1);
    tick(1);
    chk("fe_busy_lo", 32'(bus.Busy), 32'h0);
    chk("fe_count", 32'(feCount), 32'd1);
    chk("fe_data_kept", 32'(bus.RxData), 32'h81);
    chk("fe_no_done", 32'(doneCount), 32'd5);
    tick(20);
    sendFrame(8'h12, 1'b1, 0);
    tick(20);
    chk("12_data", 32'(bus.RxData), 32'h12);
    chk("12_count", 32'(doneCount), 32'd6);

    // 6: reset during data bit 4 of 0x77
    v = 8'h77;
    bus.Rx = 1'b0;
    tick(CLKS);
    for (int i = 0; i < 4; i++) begin
      bus.Rx = v[i];
      tick(CLKS);
    end
    bus.Rx = v[4];
    tick(HALF);
    chk("mid_busy", 32'(bus.Busy), 32'h1);
    Rst = 1'b1;
    bus.Rx = 1'b1;
    expQ.delete();
    tick(1);
    chk("mid_rst_busy", 32'(bus.Busy), 32'h0);
    chk("mid_rst_data", 32'(bus.RxData), 32'h00);
    tick(2);
    Rst = 1'b0;
    tick(200);
    chk("mid_no_pulse", 32'(doneCount + feCount), 32'd7);
    sendFrame(8'h77, 1'b1, 0);
    tick(20);
    chk("77_data", 32'(bus.RxData), 32'h77);
    chk("77_count", 32'(doneCount), 32'd7);
    chk("queue_empty", 32'(expQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
